// File: rtl/display_value_counter.sv
// Conditioned push-button value source for the 4-digit display driver: sync, debounce, edge-detect, bounded counter.
// Optional autorepeat on held up/down buttons, enabled by defining DISPLAY_VALUE_COUNTER_AUTOREPEAT_EN.
module display_value_counter #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [11:0] MAX_VAL         = 12'd4095,
    parameter bit          WRAP            = 1'b1,
    parameter logic [23:0] REPEAT_DELAY    = 24'd5000000,
    parameter logic [23:0] REPEAT_PERIOD   = 24'd1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_clr,
    input  logic        load,
    input  logic [11:0] load_val,
    output logic [11:0] num,
    output logic        step_pulse,
    output logic        at_max,
    output logic        at_min
);

    localparam int UP  = 0;
    localparam int DN  = 1;
    localparam int CLR = 2;

    logic [2:0]  btn_raw;
    logic [2:0]  sync1_q, sync1_d;
    logic [2:0]  sync2_q, sync2_d;
    logic [2:0]  db_q, db_d;
    logic [2:0]  db_prev_q, db_prev_d;
    logic [2:0]  ev_q, ev_d;
    logic [15:0] dc_q [3];
    logic [15:0] dc_d [3];
    logic [11:0] num_q, num_d;
    logic        step_q, step_d;
    logic        rep_up, rep_dn;
    logic        up_evt, dn_evt;

    assign btn_raw = {btn_clr, btn_down, btn_up};

    // Two-flop synchronizer, debounce counters and registered press events
    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        db_d      = db_q;
        db_prev_d = db_q;
        ev_d      = db_q & ~db_prev_q;
        for (int i = 0; i < 3; i++) begin
            dc_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (dc_q[i] == DEBOUNCE_CYCLES - 16'd1) begin
                    db_d[i] = sync2_q[i];
                    dc_d[i] = '0;
                end else begin
                    dc_d[i] = dc_q[i] + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            ev_q      <= '0;
            for (int i = 0; i < 3; i++) begin
                dc_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            ev_q      <= ev_d;
            for (int i = 0; i < 3; i++) begin
                dc_q[i] <= dc_d[i];
            end
        end
    end

`ifdef DISPLAY_VALUE_COUNTER_AUTOREPEAT_EN
    logic [23:0] hold_cnt_q, hold_cnt_d;
    logic        hold_act_q, hold_act_d;
    logic        hold_dir_up_q, hold_dir_up_d;
    logic        hold_armed_q, hold_armed_d;
    logic        held_up, held_dn;
    logic [23:0] hold_limit;

    assign held_up    = db_q[UP] & ~db_q[DN];
    assign held_dn    = db_q[DN] & ~db_q[UP];
    // First repeat waits the long delay; later ones use the shorter period
    assign hold_limit = hold_armed_q ? REPEAT_PERIOD : REPEAT_DELAY;

    always_comb begin
        hold_cnt_d    = hold_cnt_q;
        hold_act_d    = hold_act_q;
        hold_dir_up_d = hold_dir_up_q;
        hold_armed_d  = hold_armed_q;
        rep_up        = 1'b0;
        rep_dn        = 1'b0;
        if (ev_q[CLR] || load) begin
            hold_act_d   = 1'b0;
            hold_cnt_d   = '0;
            hold_armed_d = 1'b0;
        end else if (ev_q[UP] && held_up) begin
            hold_act_d    = 1'b1;
            hold_dir_up_d = 1'b1;
            hold_cnt_d    = 24'd1;
            hold_armed_d  = 1'b0;
        end else if (ev_q[DN] && held_dn) begin
            hold_act_d    = 1'b1;
            hold_dir_up_d = 1'b0;
            hold_cnt_d    = 24'd1;
            hold_armed_d  = 1'b0;
        end else if (hold_act_q && (hold_dir_up_q ? held_up : held_dn)) begin
            if (hold_cnt_q == hold_limit) begin
                rep_up       = hold_dir_up_q;
                rep_dn       = ~hold_dir_up_q;
                hold_cnt_d   = 24'd1;
                hold_armed_d = 1'b1;
            end else begin
                hold_cnt_d = hold_cnt_q + 24'd1;
            end
        end else begin
            hold_act_d   = 1'b0;
            hold_cnt_d   = '0;
            hold_armed_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q    <= '0;
            hold_act_q    <= 1'b0;
            hold_dir_up_q <= 1'b0;
            hold_armed_q  <= 1'b0;
        end else begin
            hold_cnt_q    <= hold_cnt_d;
            hold_act_q    <= hold_act_d;
            hold_dir_up_q <= hold_dir_up_d;
            hold_armed_q  <= hold_armed_d;
        end
    end
`else
    logic unused_repeat_params;

    assign unused_repeat_params = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign rep_up = 1'b0;
    assign rep_dn = 1'b0;
`endif

    assign up_evt = ev_q[UP] | rep_up;
    assign dn_evt = ev_q[DN] | rep_dn;

    // Value update in priority order: clear, load, cancel, up, down
    always_comb begin
        num_d = num_q;
        if (ev_q[CLR]) begin
            num_d = '0;
        end else if (load) begin
            num_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (up_evt && dn_evt) begin
            num_d = num_q;
        end else if (up_evt) begin
            if (num_q < MAX_VAL) begin
                num_d = num_q + 12'd1;
            end else begin
                num_d = WRAP ? 12'd0 : num_q;
            end
        end else if (dn_evt) begin
            if (num_q > 12'd0) begin
                num_d = num_q - 12'd1;
            end else begin
                num_d = WRAP ? MAX_VAL : num_q;
            end
        end
        step_d = (num_d != num_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_q  <= '0;
            step_q <= 1'b0;
        end else begin
            num_q  <= num_d;
            step_q <= step_d;
        end
    end

    assign num        = num_q;
    assign step_pulse = step_q;
    assign at_max     = (num_q == MAX_VAL);
    assign at_min     = (num_q == 12'd0);

endmodule

// File: tb/tb_display_value_counter.sv
// Directed bench for display_value_counter: a wrapping 0..9 instance and a saturating 0..999 instance share stimulus.
// Define DISPLAY_VALUE_COUNTER_AUTOREPEAT_EN to also exercise autorepeat.
module tb_display_value_counter;

    localparam logic [11:0] MAX_A = 12'd9;
    localparam logic [11:0] MAX_B = 12'd999;

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic        sa;
        logic        sb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_clr = 1'b0;
    logic        load = 1'b0;
    logic [11:0] load_val = '0;
    logic [11:0] num_a, num_b;
    logic        step_a, step_b, at_max_a, at_max_b, at_min_a, at_min_b;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [11:0] exp_a = '0;
    logic [11:0] exp_b = '0;
    exp_t        sb_q[$];

    always #5 clk = ~clk;

    display_value_counter #(
        .DEBOUNCE_CYCLES(16'd8), .MAX_VAL(MAX_A), .WRAP(1'b1),
        .REPEAT_DELAY(24'd20), .REPEAT_PERIOD(24'd10)
    ) u_dut_a (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_clr(btn_clr),
        .load(load), .load_val(load_val), .num(num_a), .step_pulse(step_a),
        .at_max(at_max_a), .at_min(at_min_a)
    );

    display_value_counter #(
        .DEBOUNCE_CYCLES(16'd8), .MAX_VAL(MAX_B), .WRAP(1'b0),
        .REPEAT_DELAY(24'd20), .REPEAT_PERIOD(24'd10)
    ) u_dut_b (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_clr(btn_clr),
        .load(load), .load_val(load_val), .num(num_b), .step_pulse(step_b),
        .at_max(at_max_b), .at_min(at_min_b)
    );

    function automatic logic [11:0] model_up(input logic [11:0] v, input logic [11:0] mx, input bit wrap);
        if (v < mx) return v + 12'd1;
        return wrap ? 12'd0 : v;
    endfunction

    function automatic logic [11:0] model_dn(input logic [11:0] v, input logic [11:0] mx, input bit wrap);
        if (v > 12'd0) return v - 12'd1;
        return wrap ? mx : v;
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [11:0] ea, input logic [11:0] eb,
                               input logic sa, input logic sb);
        chk({tag, ".num_a"}, num_a, ea);
        chk({tag, ".num_b"}, num_b, eb);
        chk({tag, ".step_a"}, {11'd0, step_a}, {11'd0, sa});
        chk({tag, ".step_b"}, {11'd0, step_b}, {11'd0, sb});
        chk({tag, ".at_max_a"}, {11'd0, at_max_a}, {11'd0, (ea == MAX_A)});
        chk({tag, ".at_min_a"}, {11'd0, at_min_a}, {11'd0, (ea == 12'd0)});
        chk({tag, ".at_max_b"}, {11'd0, at_max_b}, {11'd0, (eb == MAX_B)});
        chk({tag, ".at_min_b"}, {11'd0, at_min_b}, {11'd0, (eb == 12'd0)});
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        n_cmp++;
        assert (sb_q.size() > 0) else begin
            n_err++;
            $error("FAIL %s.queue: observed empty expected entry", tag);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_state(tag, e.a, e.b, e.sa, e.sb);
            exp_a = e.a;
            exp_b = e.b;
        end
    endtask

    // Called just after the first posedge that samples the new button level
    task automatic wait_result(input string tag);
        repeat (10) @(posedge clk);
        #1 check_state({tag, ".early"}, exp_a, exp_b, 1'b0, 1'b0);
        @(posedge clk);
        #1 pop_check(tag);
        @(posedge clk);
        #1 check_state({tag, ".after"}, exp_a, exp_b, 1'b0, 1'b0);
    endtask

    task automatic release_all(input string tag);
        @(negedge clk);
        btn_up = 1'b0;
        btn_down = 1'b0;
        btn_clr = 1'b0;
        repeat (16) @(posedge clk);
        #1 check_state({tag, ".release"}, exp_a, exp_b, 1'b0, 1'b0);
    endtask

    task automatic press(input string tag, input logic up, input logic dn, input logic clr);
        exp_t e;
        e.a = exp_a;
        e.b = exp_b;
        if (clr) begin
            e.a = '0;
            e.b = '0;
        end else if (up && !dn) begin
            e.a = model_up(exp_a, MAX_A, 1'b1);
            e.b = model_up(exp_b, MAX_B, 1'b0);
        end else if (dn && !up) begin
            e.a = model_dn(exp_a, MAX_A, 1'b1);
            e.b = model_dn(exp_b, MAX_B, 1'b0);
        end
        e.sa = (e.a != exp_a);
        e.sb = (e.b != exp_b);
        sb_q.push_back(e);
        @(negedge clk);
        btn_up = up;
        btn_down = dn;
        btn_clr = clr;
        @(posedge clk);
        wait_result(tag);
        release_all(tag);
    endtask

    task automatic do_load(input string tag, input logic [11:0] v);
        exp_t e;
        e.a = (v > MAX_A) ? MAX_A : v;
        e.b = (v > MAX_B) ? MAX_B : v;
        e.sa = (e.a != exp_a);
        e.sb = (e.b != exp_b);
        sb_q.push_back(e);
        @(negedge clk);
        load = 1'b1;
        load_val = v;
        @(posedge clk);
        #1 pop_check(tag);
        @(negedge clk);
        load = 1'b0;
        @(posedge clk);
        #1 check_state({tag, ".hold"}, exp_a, exp_b, 1'b0, 1'b0);
    endtask

    initial begin
        exp_t e;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1 check_state("idle", 12'd0, 12'd0, 1'b0, 1'b0);
        end

        @(negedge clk);
        btn_up = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        btn_up = 1'b0;
        repeat (20) @(posedge clk);
        #1 check_state("glitch", 12'd0, 12'd0, 1'b0, 1'b0);

        press("up1", 1'b1, 1'b0, 1'b0);
        do_load("load9", 12'd9);
        press("up_wrap", 1'b1, 1'b0, 1'b0);
        press("dn_wrap", 1'b0, 1'b1, 1'b0);
        do_load("load4095", 12'd4095);
        press("up_sat", 1'b1, 1'b0, 1'b0);
        do_load("load5", 12'd5);
        press("clr_up", 1'b1, 1'b0, 1'b1);
        do_load("load3", 12'd3);
        press("up_dn", 1'b1, 1'b1, 1'b0);
        do_load("load0", 12'd0);
        press("dn_at0", 1'b0, 1'b1, 1'b0);

        do_load("load7", 12'd7);
        @(negedge clk);
        btn_down = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 check_state("midrst", 12'd0, 12'd0, 1'b0, 1'b0);
        exp_a = '0;
        exp_b = '0;
        e.a = model_dn(12'd0, MAX_A, 1'b1);
        e.b = model_dn(12'd0, MAX_B, 1'b0);
        e.sa = 1'b1;
        e.sb = 1'b0;
        sb_q.push_back(e);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        wait_result("dn_after_rst");
        release_all("dn_after_rst");

`ifdef DISPLAY_VALUE_COUNTER_AUTOREPEAT_EN
        do_load("rep_load0", 12'd0);
        e.a = 12'd1;
        e.b = 12'd1;
        e.sa = 1'b1;
        e.sb = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        btn_up = 1'b1;
        @(posedge clk);
        wait_result("rep1");
        repeat (17) @(posedge clk);
        #1 check_state("rep2.early", 12'd1, 12'd1, 1'b0, 1'b0);
        @(posedge clk);
        #1 check_state("rep2", 12'd2, 12'd2, 1'b1, 1'b1);
        for (int k = 3; k <= 4; k++) begin
            repeat (9) @(posedge clk);
            #1 check_state("repN.early", 12'(k - 1), 12'(k - 1), 1'b0, 1'b0);
            @(posedge clk);
            #1 check_state("repN", 12'(k), 12'(k), 1'b1, 1'b1);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        btn_up = 1'b0;
        repeat (5) @(posedge clk);
        #1 check_state("rep5.early", 12'd4, 12'd4, 1'b0, 1'b0);
        @(posedge clk);
        #1 check_state("rep5", 12'd5, 12'd5, 1'b1, 1'b1);
        repeat (40) @(posedge clk);
        #1 check_state("rep_stop", 12'd5, 12'd5, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
